// File: rtl/ge_channel_pkg.sv
// Shared constants for the Gilbert-Elliott burst-noise channel model.
// State and mode encodings, plus nominal gains at GAIN_FRAC = 6.
package ge_channel_pkg;

  localparam logic CH_GOOD = 1'b0;
  localparam logic CH_BAD  = 1'b1;

  typedef enum logic [1:0] {
    MODE_MARKOV     = 2'd0,
    MODE_FORCE_GOOD = 2'd1,
    MODE_FORCE_BAD  = 2'd2,
    MODE_BYPASS     = 2'd3
  } ch_mode_e;

  // 65/64 ~ +0.1 dB, 78/64 ~ +1.7 dB
  localparam int GAIN_GOOD_DEF = 65;
  localparam int GAIN_BAD_DEF  = 78;

endpackage

// File: rtl/ge_gain_sat.sv
// Combinational unsigned fixed-point scaler: full-width multiply, truncating
// shift by GAIN_FRAC, then saturate to DATA_W. Bypass passes din unchanged.
module ge_gain_sat #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6
) (
  input  logic [DATA_W-1:0] din,
  input  logic [GAIN_W-1:0] gain,
  input  logic              bypass,
  output logic [DATA_W-1:0] dout
);

  localparam int PROD_W = DATA_W + GAIN_W;

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] shifted;
  logic              ovf;

  assign prod    = {{GAIN_W{1'b0}}, din} * {{DATA_W{1'b0}}, gain};
  assign shifted = prod >> GAIN_FRAC;
  assign ovf     = |shifted[PROD_W-1:DATA_W];

  always_comb begin
    dout = shifted[DATA_W-1:0];
    if (ovf)    dout = '1;
    if (bypass) dout = din;
  end

endmodule

// File: rtl/ge_channel_model.sv
// Two-state Gilbert-Elliott channel: scales each accepted sample by the gain of
// the effective state, advances the Markov state, and keeps BAD-burst statistics.
module ge_channel_model
  import ge_channel_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RAND_W    = 8,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [RAND_W-1:0] rand_int,
  input  logic [RAND_W-1:0] thr_gb,
  input  logic [RAND_W-1:0] thr_bg,
  input  logic [GAIN_W-1:0] gain_good,
  input  logic [GAIN_W-1:0] gain_bad,
  input  logic [1:0]        mode,
  input  logic              clear_stats,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              chan_state,
  output logic [CNT_W-1:0]  bad_count,
  output logic [CNT_W-1:0]  burst_len,
  output logic [CNT_W-1:0]  max_burst
);

  ch_mode_e          mode_e;
  logic              state_q;
  logic              s_eff;
  logic              state_nxt;
  logic [GAIN_W-1:0] gain_sel;
  logic [DATA_W-1:0] scaled;
  logic [CNT_W-1:0]  bad_inc;
  logic [CNT_W-1:0]  burst_inc;

  assign mode_e     = ch_mode_e'(mode);
  assign chan_state = state_q;

  // Effective state applied to this sample and the state register's next value
  always_comb begin
    s_eff     = state_q;
    state_nxt = state_q;
    case (mode_e)
      MODE_FORCE_GOOD: begin s_eff = CH_GOOD; state_nxt = CH_GOOD; end
      MODE_FORCE_BAD:  begin s_eff = CH_BAD;  state_nxt = CH_BAD;  end
      default: begin
        if (state_q == CH_GOOD) begin
          if (rand_int <= thr_gb) state_nxt = CH_BAD;
        end else begin
          if (rand_int <= thr_bg) state_nxt = CH_GOOD;
        end
      end
    endcase
  end

  assign gain_sel = (s_eff == CH_BAD) ? gain_bad : gain_good;

  ge_gain_sat #(
    .DATA_W   (DATA_W),
    .GAIN_W   (GAIN_W),
    .GAIN_FRAC(GAIN_FRAC)
  ) u_gain_sat (
    .din   (data_in),
    .gain  (gain_sel),
    .bypass(mode_e == MODE_BYPASS),
    .dout  (scaled)
  );

  assign bad_inc   = (bad_count == '1) ? bad_count : bad_count + CNT_W'(1);
  assign burst_inc = (burst_len == '1) ? burst_len : burst_len + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CH_GOOD;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state_q  <= state_nxt;
        data_out <= scaled;
      end
    end
  end

  // Clear takes priority over a same-cycle accept; that sample goes uncounted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_count <= '0;
      burst_len <= '0;
      max_burst <= '0;
    end else if (clear_stats) begin
      bad_count <= '0;
      burst_len <= '0;
      max_burst <= '0;
    end else if (in_valid) begin
      if (s_eff == CH_BAD) begin
        bad_count <= bad_inc;
        burst_len <= burst_inc;
        if (burst_inc > max_burst) max_burst <= burst_inc;
      end else begin
        burst_len <= '0;
      end
    end
  end

endmodule

// File: doc/ge_channel_model.md
Name: ge_channel_model

Overview:
- Parametrised two-state Gilbert-Elliott burst-noise channel: each accepted sample is scaled by the gain of the current channel state (GOOD/BAD), then the state advances on a random draw against run-time thresholds.
- Sits between the transmitter modulator and the receiver front end in the communication-system datapath; the random source is the shared LFSR block.
- Adds valid handshake, run-time gains/thresholds, forced-state modes, saturating arithmetic and burst statistics.

Parameters:
- DATA_W, 16, sample width (unsigned).
- RAND_W, 8, width of random draw and thresholds.
- GAIN_W, 8, gain width, unsigned fixed point.
- GAIN_FRAC, 6, fractional bits of gain (64 = 1.0).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present on data_in this cycle.
- data_in  in  DATA_W  input sample.
- rand_int  in  RAND_W  random draw, consumed only on accepted samples.
- thr_gb  in  RAND_W  GOOD->BAD threshold (transition if rand_int <= thr_gb).
- thr_bg  in  RAND_W  BAD->GOOD threshold (transition if rand_int <= thr_bg).
- gain_good  in  GAIN_W  GOOD-state gain.
- gain_bad  in  GAIN_W  BAD-state gain.
- mode  in  2  0 Markov, 1 force GOOD, 2 force BAD, 3 bypass (gain 1.0, Markov state still advances).
- clear_stats  in  1  synchronous clear of statistics.
- out_valid  out  1  data_out valid.
- data_out  out  DATA_W  scaled sample.
- chan_state  out  1  state register (0 GOOD, 1 BAD).
- bad_count  out  CNT_W  samples processed in BAD state.
- burst_len  out  CNT_W  current consecutive BAD-sample run.
- max_burst  out  CNT_W  longest BAD run since clear.

Behaviour:
- Reset (async, any time incl. mid-stream): state GOOD; out_valid 0; data_out 0; all counters 0. In-flight sample is dropped.
- Accept = in_valid. No backpressure; one sample per cycle max.
- Effective state S for an accepted sample: mode 0/3 -> state register; mode 1 -> GOOD; mode 2 -> BAD.
- Datapath: product = data_in * gain(S) (DATA_W+GAIN_W bits, full width); result = product >> GAIN_FRAC (truncate); if result > 2^DATA_W-1 then data_out = 2^DATA_W-1 (saturate). Mode 3 passes data_in unchanged.
- Latency 1: data_out/out_valid registered on the cycle after acceptance; out_valid = registered in_valid. data_out holds its last value when out_valid is 0.
- Next state on accept: mode 0/3: GOOD -> BAD iff rand_int <= thr_gb; BAD -> GOOD iff rand_int <= thr_bg; else hold. Mode 1/2: state register loads the forced state, rand_int ignored. No accept: state holds.
- thr = 0 still transitions on rand_int = 0; thr = 2^RAND_W-1 transitions every sample.
- Statistics, on accept with S = BAD: bad_count +1; burst_len +1; max_burst = max(max_burst, burst_len+1). S = GOOD: burst_len -> 0. All counters saturate at 2^CNT_W-1, never wrap.
- clear_stats same cycle as accept: clear wins, that sample is not counted; state register and datapath unaffected.
- Gains, thresholds, mode are sampled only on accepted cycles; changes between samples take effect on the next accept.

Decomposition:
- Package ge_channel_pkg: state constants CH_GOOD=1'b0, CH_BAD=1'b1; mode constants MODE_MARKOV, MODE_FORCE_GOOD, MODE_FORCE_BAD, MODE_BYPASS; default gain constants (65, 78 at GAIN_FRAC=6).
- One sub-module: ge_gain_sat (combinational multiply, shift, saturate; parameters DATA_W, GAIN_W, GAIN_FRAC). State register, handshake and counters stay in the top.

Test Plan:
- Reset, mode 0, gains 65/78, thr_gb=2, thr_bg=24; data_in=1000, rand_int=200 -> next cycle out_valid=1, data_out=1015, chan_state stays GOOD.
- GOOD, rand_int=2 -> state BAD; next sample 1000, rand_int=25 -> data_out=1218, state stays BAD, bad_count=1, burst_len=1; rand_int=3 on first GOOD sample -> no transition.
- BAD, data_in=60000 -> data_out=65535 (saturated); 3 BAD samples then rand_int=24 -> after next GOOD sample burst_len=0, max_burst=4.
- mode=2 with rand_int=0 -> gain 78 applied, state register BAD; mode=3 -> data_out=data_in exactly, state still advances per thresholds.
- in_valid gaps (1,0,0,1): state and counters change only on the two accepts; out_valid follows in_valid by one cycle. clear_stats with accept -> counters 0.
- Assert reset mid-stream in BAD with counters nonzero -> out_valid, data_out, chan_state, bad_count, burst_len, max_burst all 0 immediately, before the next clock edge.
